// File: rtl/sensor_scan_demux_if.sv
// rtl/sensor_scan_demux_if.sv - mux select and ADC sample handshake between scan controller and front end
interface sensor_scan_demux_if #(
  parameter int SIGNAL_WIDTH = 12
);
  logic [1:0]              sel;
  logic                    sample_req;
  logic                    sample_valid;
  logic [SIGNAL_WIDTH-1:0] sample_data;

  modport master (
    output sel,
    output sample_req,
    input  sample_valid,
    input  sample_data
  );

  modport slave (
    input  sel,
    input  sample_req,
    output sample_valid,
    output sample_data
  );
endinterface

// File: rtl/sensor_scan_demux.sv
// rtl/sensor_scan_demux.sv - 4-channel sensor scan controller: settle, sample, demux into channel registers
module sensor_scan_demux #(
  parameter int SIGNAL_WIDTH   = 12,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  sensor_scan_demux_if.master     adc,
  output logic [SIGNAL_WIDTH-1:0] ch0,
  output logic [SIGNAL_WIDTH-1:0] ch1,
  output logic [SIGNAL_WIDTH-1:0] ch2,
  output logic [SIGNAL_WIDTH-1:0] ch3,
  output logic [3:0]              ch_valid,
  output logic                    frame_done,
  output logic                    timeout_err
);

  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_REQ    = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [1:0]              sel_q, sel_d;
  logic                    req_q, req_d;
  logic                    frame_done_q, frame_done_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [3:0]              ch_valid_q, ch_valid_d;
  logic [SIGNAL_WIDTH-1:0] ch_q [4];
  logic [SIGNAL_WIDTH-1:0] ch_d [4];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sel_d         = sel_q;
    req_d         = 1'b0;
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;
    ch_valid_d    = ch_valid_q;
    ch_d          = ch_q;

    case (state_q)
      ST_IDLE: begin
        sel_d = 2'd0;
        if (enable) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end

      ST_SETTLE: begin
        // Request is raised on entry to REQ so the registered pulse covers exactly the REQ cycle.
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_REQ;
          cnt_d   = '0;
          req_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_REQ: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end

      ST_WAIT: begin
        // A sample arriving on the last timeout cycle still counts as a good capture.
        if (adc.sample_valid) begin
          ch_d[sel_q]       = adc.sample_data;
          ch_valid_d[sel_q] = 1'b1;
          state_d           = ST_NEXT;
          frame_done_d      = (sel_q == 2'd3);
        end else if (cnt_q == TIMEOUT_LAST) begin
          ch_valid_d[sel_q] = 1'b0;
          timeout_err_d     = 1'b1;
          state_d           = ST_NEXT;
          frame_done_d      = (sel_q == 2'd3);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_NEXT: begin
        cnt_d = '0;
        if (sel_q != 2'd3) begin
          sel_d   = sel_q + 2'd1;
          state_d = ST_SETTLE;
        end else begin
          sel_d   = 2'd0;
          state_d = enable ? ST_SETTLE : ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sel_q         <= 2'd0;
      req_q         <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      ch_valid_q    <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        ch_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      req_q         <= req_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      ch_valid_q    <= ch_valid_d;
      ch_q          <= ch_d;
    end
  end

  assign adc.sel        = sel_q;
  assign adc.sample_req = req_q;
  assign ch0            = ch_q[0];
  assign ch1            = ch_q[1];
  assign ch2            = ch_q[2];
  assign ch3            = ch_q[3];
  assign ch_valid       = ch_valid_q;
  assign frame_done     = frame_done_q;
  assign timeout_err    = timeout_err_q;

endmodule
